// File: rtl/random_requester_pkg.sv
// Shared constants for the random requester: FSM state encoding and the LCG
// generator parameters that the bench model reproduces.
package random_requester_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DIV     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // LCG: x' = (a*x + c) mod 2^31
    localparam logic [31:0] LCG_SEED = 32'd13;
    localparam logic [31:0] LCG_A    = 32'd22695477;
    localparam logic [31:0] LCG_C    = 32'd1;
    localparam int          LCG_BITS = 31;

endpackage

// File: rtl/serial_mod.sv
// Bit-serial restoring remainder: 32 steps, MSB first. done and remainder are
// valid during the cycle whose edge performs the final step.
module serial_mod #(
    parameter int RANGE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        dividend,
    input  logic [RANGE_W-1:0] divisor,
    output logic               done,
    output logic [RANGE_W-1:0] remainder
);

    logic [31:0]      dvd_reg;
    logic [RANGE_W:0] rem_reg;
    logic [4:0]       idx_reg;
    logic             active_reg;
    logic [RANGE_W:0] shifted;
    logic [RANGE_W:0] rem_next;

    // rem is always < divisor, so its low RANGE_W bits carry the full value
    always_comb begin
        shifted  = {rem_reg[RANGE_W-1:0], dvd_reg[idx_reg]};
        rem_next = shifted;
        if (shifted >= {1'b0, divisor}) begin
            rem_next = shifted - {1'b0, divisor};
        end
    end

    assign done      = active_reg && (idx_reg == 5'd0);
    assign remainder = rem_next[RANGE_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_reg    <= '0;
            rem_reg    <= '0;
            idx_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            dvd_reg    <= dividend;
            rem_reg    <= '0;
            idx_reg    <= 5'd31;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            rem_reg <= rem_next;
            idx_reg <= idx_reg - 5'd1;
            if (idx_reg == 5'd0) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/random_requester.sv
// Requests one value from the LCG generator, reduces it modulo range and
// returns it over a valid/ready handshake.
module random_requester
    import random_requester_pkg::*;
#(
    parameter int RANGE_W     = 16,
    parameter int WAIT_CYCLES = 4,
    parameter int DROP_LSB    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [RANGE_W-1:0] range,
    output logic               rnd_request,
    input  logic [31:0]        rnd_in,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [RANGE_W-1:0] result,
    output logic               range_err
);

    logic [2:0]         state_reg;
    logic [RANGE_W-1:0] range_reg;
    logic [15:0]        wcnt_reg;
    logic [31:0]        dividend;
    logic               mod_start;
    logic               mod_done;
    logic [RANGE_W-1:0] mod_rem;

    assign busy      = (state_reg != ST_IDLE);
    assign dividend  = rnd_in >> DROP_LSB;
    assign mod_start = (state_reg == ST_CAPTURE);

    serial_mod #(
        .RANGE_W (RANGE_W)
    ) u_serial_mod (
        .clk       (clk),
        .reset     (reset),
        .start     (mod_start),
        .dividend  (dividend),
        .divisor   (range_reg),
        .done      (mod_done),
        .remainder (mod_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            range_reg    <= '0;
            wcnt_reg     <= '0;
            rnd_request  <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            range_err    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (range != '0) begin
                            range_reg   <= range;
                            rnd_request <= 1'b1;
                            state_reg   <= ST_REQ;
                        end else begin
                            // A zero modulus is reported without bothering the generator
                            result       <= '0;
                            range_err    <= 1'b1;
                            result_valid <= 1'b1;
                            state_reg    <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    rnd_request <= 1'b0;
                    wcnt_reg    <= '0;
                    state_reg   <= ST_WAIT;
                end
                ST_WAIT: begin
                    wcnt_reg <= wcnt_reg + 16'd1;
                    if (wcnt_reg == 16'(WAIT_CYCLES - 1)) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state_reg <= ST_DIV;
                end
                ST_DIV: begin
                    if (mod_done) begin
                        result       <= mod_rem;
                        range_err    <= 1'b0;
                        result_valid <= 1'b1;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_requester.sv
// Randomized self-checking bench for random_requester against an arithmetic
// reference model (plain % on the drawn value, LCG computed with longint).
module tb_random_requester;
    import random_requester_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, result_ready, use_gen;
    logic [15:0] range;
    logic [31:0] stub_val, rnd_in;
    logic [31:0] gen_state = LCG_SEED;
    logic        rnd_request, busy, result_valid, range_err;
    logic [15:0] result;

    logic        start2, ready2;
    logic [15:0] range2;
    logic [31:0] rnd_in2;
    logic        req2, busy2, valid2, err2;
    logic [15:0] result2;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          req_count = 0;
    logic [31:0] model_state = LCG_SEED;
    logic [15:0] last_res;

    always #5 clk = ~clk;

    assign rnd_in = use_gen ? gen_state : stub_val;

    random_requester #(.RANGE_W(16), .WAIT_CYCLES(4), .DROP_LSB(0)) dut (
        .clk(clk), .reset(reset), .start(start), .range(range),
        .rnd_request(rnd_request), .rnd_in(rnd_in), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .range_err(range_err)
    );

    random_requester #(.RANGE_W(16), .WAIT_CYCLES(4), .DROP_LSB(8)) dut_drop (
        .clk(clk), .reset(reset), .start(start2), .range(range2),
        .rnd_request(req2), .rnd_in(rnd_in2), .busy(busy2),
        .result_valid(valid2), .result_ready(ready2),
        .result(result2), .range_err(err2)
    );

    function automatic logic [31:0] model_lcg(input logic [31:0] x);
        longint unsigned t;
        t = longint'(LCG_A) * longint'(x) + longint'(LCG_C);
        return 32'(t % (64'd1 << LCG_BITS));
    endfunction

    // Generator stand-in: advances one step per request pulse
    always @(posedge clk) begin
        if (rnd_request) req_count++;
        if (rnd_request && use_gen) gen_state <= model_lcg(gen_state);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_draw(input logic [31:0] val, input logic [15:0] rng, input bit gen,
                            input int hold, input bit poke, output logic [15:0] got);
        int          n;
        int          req0;
        logic [31:0] src;
        logic [31:0] exp;
        stub_val = val;
        use_gen  = gen;
        range    = rng;
        req0     = req_count;
        if (gen) begin
            model_state = model_lcg(model_state);
            src = model_state;
        end else begin
            src = val;
        end
        exp = (rng == 16'd0) ? 32'd0 : (src % {16'd0, rng});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        range = 16'($urandom);
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (!result_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 10 && !gen) stub_val = $urandom;
            start = (poke && n == 20);
        end
        start = 1'b0;
        check_eq("latency", n, (rng == 16'd0) ? 32'd0 : 32'd38);
        check_eq("result", {16'd0, result}, exp);
        check_eq("range_err", {31'd0, range_err}, {31'd0, (rng == 16'd0)});
        for (int h = 0; h < hold; h++) begin
            start = (poke && h == 0);
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("hold_valid", {31'd0, result_valid}, 32'd1);
            check_eq("hold_result", {16'd0, result}, exp);
        end
        start = poke;
        result_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        result_ready = 1'b0;
        check_eq("idle_after_ack", {30'd0, busy, result_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("still_idle", {31'd0, busy}, 32'd0);
        check_eq("req_pulses", req_count - req0, (rng != 16'd0) ? 32'd1 : 32'd0);
        got = result;
        $display("[TB] draw src=0x%08h range=%0d result=%0d expected=%0d latency=%0d",
                 src, rng, result, exp, n);
    endtask

    task automatic run_drop(input logic [31:0] val, input logic [15:0] rng);
        int          n;
        logic [31:0] exp;
        exp     = (val >> 8) % {16'd0, rng};
        rnd_in2 = val;
        range2  = rng;
        start2  = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drop_latency", n, 32'd38);
        check_eq("drop_result", {16'd0, result2}, exp);
        check_eq("drop_err", {31'd0, err2}, 32'd0);
        ready2 = 1'b1;
        @(posedge clk); #1;
        ready2 = 1'b0;
        check_eq("drop_idle", {31'd0, busy2}, 32'd0);
        $display("[TB] drop draw src=0x%08h range=%0d result=%0d expected=%0d",
                 val, rng, result2, exp);
    endtask

    initial begin
        int          n;
        int          req0;
        logic [15:0] rng;
        reset = 1'b1; start = 1'b0; result_ready = 1'b0; use_gen = 1'b0;
        range = '0; stub_val = '0;
        start2 = 1'b0; ready2 = 1'b0; range2 = '0; rnd_in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", {27'd0, rnd_request, busy, result_valid, range_err, 1'b0}, 32'd0);
        check_eq("reset_result", {16'd0, result}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Stub value, small modulus
        run_draw(32'd1000, 16'd7, 1'b0, 2, 1'b0, last_res);
        check_eq("t1_result", {16'd0, last_res}, 32'd6);

        // Reset while in REQ clears outputs without a clock edge
        stub_val = 32'd1000; use_gen = 1'b0; range = 16'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("req_high", {31'd0, rnd_request}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_req_outs", {28'd0, rnd_request, busy, result_valid, range_err}, 32'd0);
        check_eq("rst_req_result", {16'd0, result}, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        run_draw(32'd1000, 16'd7, 1'b0, 0, 1'b0, last_res);

        // Reset while in DIV
        req0 = req_count;
        range = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_div_outs", {28'd0, rnd_request, busy, result_valid, range_err}, 32'd0);
        check_eq("rst_div_result", {16'd0, result}, 32'd0);
        check_eq("rst_div_reqs", req_count - req0, 32'd1);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        run_draw(32'd123457, 16'd1000, 1'b0, 1, 1'b0, last_res);

        // Real LCG sequence
        run_draw(32'd0, 16'd6, 1'b1, 0, 1'b0, last_res);
        check_eq("lcg_first", {16'd0, last_res}, 32'd4);
        run_draw(32'd0, 16'd100, 1'b1, 1, 1'b0, last_res);

        // Boundary moduli
        run_draw(32'hDEAD_BEEF, 16'd0, 1'b0, 1, 1'b0, last_res);
        run_draw(32'hDEAD_BEEF, 16'd1, 1'b0, 1, 1'b0, last_res);

        // Long hold with start pokes in DIV, DONE and the handshake cycle
        run_draw(32'd987654321, 16'd997, 1'b0, 20, 1'b1, last_res);

        // Randomized draws
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 9))
                0:       rng = 16'd0;
                1:       rng = 16'd1;
                2:       rng = 16'hFFFF;
                default: rng = 16'($urandom_range(2, 65535));
            endcase
            run_draw($urandom, rng, ($urandom_range(0, 3) == 0), $urandom_range(0, 5),
                     ($urandom_range(0, 1) == 1), last_res);
        end

        // Low-bit drop instance
        run_drop(32'hFFFF_FFFF, 16'hFFFF);
        check_eq("t6_result", {16'd0, result2}, 32'd255);
        for (int k = 0; k < 4; k++) begin
            run_drop($urandom, 16'($urandom_range(1, 65535)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
